// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared types and constants for the iterative divider
package div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    // A set top bit in the shifted remainder always exceeds the divisor.
    assign borrow  = ~shifted[WIDTH] & trial[WIDTH];

    assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle DIV/DIVU unit; optional DIV_ZERO_FAST_EN short-cuts zero divisors
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_startE,
    input  logic               div_signedE,
    input  logic [WIDTH-1:0]   div_srcaE,
    input  logic [WIDTH-1:0]   div_srcbE,
    input  logic               stallE,
    input  logic               flush_exceptionM,
    output logic               div_stallE,
    output logic [2*WIDTH-1:0] div_resultE,
    output logic               div_readyE
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, abs_b, a_raw;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             q_neg, r_neg, b_zero;
    logic             a_sign, b_sign;
    logic [WIDTH-1:0] abs_a_in, abs_b_in;
    logic             accept, last_step, zero_fast;

    assign a_sign    = div_signedE & div_srcaE[WIDTH-1];
    assign b_sign    = div_signedE & div_srcbE[WIDTH-1];
    assign abs_a_in  = a_sign ? -div_srcaE : div_srcaE;
    assign abs_b_in  = b_sign ? -div_srcbE : div_srcbE;
    assign accept    = (state == IDLE) && div_startE && !flush_exceptionM;
    assign last_step = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (div_srcbE == '0);
`else
    assign zero_fast = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (abs_b),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_startE) state_next = zero_fast ? DONE : BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (!stallE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_exceptionM) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            abs_b       <= '0;
            a_raw       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            b_zero      <= 1'b0;
            div_resultE <= '0;
        end else if (accept) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= abs_a_in;
            abs_b  <= abs_b_in;
            a_raw  <= div_srcaE;
            q_neg  <= a_sign ^ b_sign;
            r_neg  <= a_sign;
            b_zero <= (div_srcbE == '0);
            if (zero_fast) div_resultE <= {div_srcaE, {WIDTH{1'b1}}};
        end else if (state == BUSY && !flush_exceptionM) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                // Zero divisor reports the raw dividend, not the algorithm's output.
                if (b_zero) div_resultE <= {a_raw, {WIDTH{1'b1}}};
                else        div_resultE <= {r_neg ? -rem_step : rem_step,
                                            q_neg ? -quo_step : quo_step};
            end
        end
    end

    assign div_stallE = ~flush_exceptionM &
                        (((state == IDLE) & div_startE) | (state == BUSY));
    assign div_readyE = (state == DONE);

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter
module tb_div_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          div_startE = 1'b0;
    logic          div_signedE = 1'b0;
    logic [W-1:0]  div_srcaE = '0;
    logic [W-1:0]  div_srcbE = '0;
    logic          stallE = 1'b0;
    logic          flush_exceptionM = 1'b0;
    logic          div_stallE;
    logic [2*W-1:0] div_resultE;
    logic          div_readyE;

    int n_cmp = 0;
    int n_bad = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .div_startE       (div_startE),
        .div_signedE      (div_signedE),
        .div_srcaE        (div_srcaE),
        .div_srcbE        (div_srcbE),
        .stallE           (stallE),
        .flush_exceptionM (flush_exceptionM),
        .div_stallE       (div_stallE),
        .div_resultE      (div_resultE),
        .div_readyE       (div_readyE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MIPS semantics from 64-bit arithmetic: truncating quotient, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : W + 1;
`else
        return (b == 32'd0) ? W + 1 : W + 1;
`endif
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           output logic [63:0] res, output int stalls, output bit got);
        div_srcaE   = a;
        div_srcbE   = b;
        div_signedE = s;
        div_startE  = 1'b1;
        stalls = 0;
        got    = 1'b0;
        res    = '0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (div_readyE) begin
                got = 1'b1;
                res = div_resultE;
                break;
            end
            if (div_stallE) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic leave_done(input string name);
        @(negedge clk);
        div_startE = 1'b0;
        #1;
        check({name, "_idle"}, {63'd0, div_readyE}, 64'd0);
    endtask

    task automatic full_check(input string name, input logic [31:0] a, input logic [31:0] b,
                              input bit s, input logic [63:0] exp);
        logic [63:0] res;
        int          st;
        bit          got;
        @(negedge clk);
        run_div(a, b, s, res, st, got);
        check({name, "_ready"}, {63'd0, got}, 64'd1);
        check({name, "_result"}, res, exp);
        check({name, "_stalls"}, 64'(st), 64'(exp_lat(b)));
        leave_done(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        int          st;
        bit          got;
        logic [31:0] ra, rb;
        bit          rs;

        vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2, 32'd14}};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000}};
        vecs[3] = '{32'd5,          32'd0,          1'b0, {32'd5, 32'hFFFF_FFFF}};
        vecs[4] = '{32'd5,          32'd0,          1'b1, {32'd5, 32'hFFFF_FFFF}};
        vecs[5] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD}};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          1'b0, {32'd1, 32'h7FFF_FFFF}};
        vecs[7] = '{32'd0,          32'd9,          1'b0, {32'd0, 32'd0}};
        vecs[8] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0}};
        vecs[9] = '{32'hF000_0000,  32'd0,          1'b1, {32'hF000_0000, 32'hFFFF_FFFF}};

        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", {63'd0, div_readyE}, 64'd0);
        check("reset_result", div_resultE, 64'd0);
        check("reset_stall", {63'd0, div_stallE}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            full_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else                                rb = $urandom_range(1, 50);
            rs = 1'($urandom_range(0, 1));
            full_check($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // Hold stallE through DONE: result stays put and nothing restarts.
        @(negedge clk);
        run_div(32'd100, 32'd7, 1'b0, res, st, got);
        check("hold_ready", {63'd0, got}, 64'd1);
        stallE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) stallE = 1'b0;
            #1;
            check($sformatf("hold%0d_ready", k), {63'd0, div_readyE}, 64'd1);
            check($sformatf("hold%0d_result", k), div_resultE, {32'd2, 32'd14});
            check($sformatf("hold%0d_stall", k), {63'd0, div_stallE}, 64'd0);
            @(negedge clk);
        end
        div_startE = 1'b0;
        #1;
        check("hold_idle_ready", {63'd0, div_readyE}, 64'd0);
        @(negedge clk);
        #1;
        check("hold_norestart_stall", {63'd0, div_stallE}, 64'd0);
        check("hold_norestart_ready", {63'd0, div_readyE}, 64'd0);

        // Flush at iteration 10.
        @(negedge clk);
        div_srcaE = 32'd100; div_srcbE = 32'd7; div_signedE = 1'b0; div_startE = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check("flush_busy_stall", {63'd0, div_stallE}, 64'd1);
        flush_exceptionM = 1'b1;
        #1;
        check("flush_stall_same", {63'd0, div_stallE}, 64'd0);
        @(negedge clk);
        flush_exceptionM = 1'b0;
        div_startE = 1'b0;
        #1;
        check("flush_ready", {63'd0, div_readyE}, 64'd0);
        check("flush_idle_stall", {63'd0, div_stallE}, 64'd0);
        full_check("after_flush", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Start coinciding with flush in IDLE is dropped.
        @(negedge clk);
        div_srcaE = 32'd50; div_srcbE = 32'd5; div_startE = 1'b1; flush_exceptionM = 1'b1;
        #1;
        check("idle_flush_stall", {63'd0, div_stallE}, 64'd0);
        @(negedge clk);
        div_startE = 1'b0; flush_exceptionM = 1'b0;
        #1;
        check("idle_flush_nostart", {63'd0, div_stallE}, 64'd0);

        // Reset at iteration 20.
        @(negedge clk);
        div_srcaE = 32'd1000; div_srcbE = 32'd3; div_signedE = 1'b0; div_startE = 1'b1;
        repeat (21) @(negedge clk);
        #1;
        check("rst_busy_stall", {63'd0, div_stallE}, 64'd1);
        rst = 1'b0;
        div_startE = 1'b0;
        #1;
        check("rst_mid_ready", {63'd0, div_readyE}, 64'd0);
        check("rst_mid_result", div_resultE, 64'd0);
        check("rst_mid_stall", {63'd0, div_stallE}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        full_check("after_rst", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
